// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding,
// checksum width and the modular checksum adder.
package carregador_instrucoes_pkg;

    localparam int CHECKSUM_W = 8;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        RECEBENDO   = 2'd1,
        VERIFICANDO = 2'd2,
        FIM         = 2'd3
    } estado_t;

    // Checksum accumulates with natural wrap-around (mod 2^CHECKSUM_W).
    function automatic logic [CHECKSUM_W-1:0] soma_mod(
        input logic [CHECKSUM_W-1:0] a,
        input logic [CHECKSUM_W-1:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/carregador_instrucoes.sv
// Instruction loader: receives a byte stream plus checksum, writes it into
// instruction memory and releases the CPU reset only on a verified load.
module carregador_instrucoes
    import carregador_instrucoes_pkg::*;
#(
    parameter logic [7:0] BASE           = 8'd0,
    parameter int         TIMEOUT_CICLOS = 1000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_inicio,
    input  logic [7:0] i_tamanho,
    input  logic       i_dado_valido,
    input  logic [7:0] i_dado,
    output logic       o_dado_pronto,
    output logic       o_mem_escrita,
    output logic [7:0] o_mem_endereco,
    output logic [7:0] o_mem_dado,
    output logic       o_ocupado,
    output logic       o_concluido,
    output logic       o_erro,
    output logic       o_cpu_reset
);

    localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS + 1) : 1;

    estado_t               r_estado;
    estado_t               w_prox_estado;
    logic [7:0]            r_tamanho;
    logic [7:0]            r_indice;
    logic [CHECKSUM_W-1:0] r_soma;
    logic [CNT_W-1:0]      r_ocioso;
    logic                  r_erro;
    logic                  r_cpu_reset;
    logic                  r_wr_vld_p1;
    logic [7:0]            r_wr_end_p1;
    logic [7:0]            r_wr_dado_p1;

    logic w_pronto;
    logic w_transf;
    logic w_timeout;
    logic w_ultimo;
    logic w_passa;

    assign w_pronto  = (r_estado == RECEBENDO) || (r_estado == VERIFICANDO);
    assign w_transf  = i_dado_valido && w_pronto;
    assign w_timeout = !w_transf && (r_ocioso == CNT_W'(TIMEOUT_CICLOS - 1));
    assign w_ultimo  = (r_indice == r_tamanho);
    assign w_passa   = (soma_mod(r_soma, i_dado) == '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO:      if (i_inicio) w_prox_estado = RECEBENDO;
            RECEBENDO: begin
                if (w_transf && w_ultimo) w_prox_estado = VERIFICANDO;
                else if (w_timeout)       w_prox_estado = FIM;
            end
            VERIFICANDO: if (w_transf || w_timeout) w_prox_estado = FIM;
            FIM:         w_prox_estado = OCIOSO;
            default:     w_prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tamanho    <= '0;
            r_indice     <= '0;
            r_soma       <= '0;
            r_ocioso     <= '0;
            r_erro       <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_wr_vld_p1  <= 1'b0;
            r_wr_end_p1  <= '0;
            r_wr_dado_p1 <= '0;
        end else begin
            r_wr_vld_p1 <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (i_inicio) begin
                        r_tamanho   <= i_tamanho;
                        r_indice    <= '0;
                        r_soma      <= '0;
                        r_ocioso    <= '0;
                        r_erro      <= 1'b0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                RECEBENDO: begin
                    if (w_transf) begin
                        // stage p1: memory write issued the cycle after the transfer
                        r_soma       <= soma_mod(r_soma, i_dado);
                        r_ocioso     <= '0;
                        r_wr_vld_p1  <= 1'b1;
                        r_wr_end_p1  <= BASE + r_indice;
                        r_wr_dado_p1 <= i_dado;
                        if (!w_ultimo) r_indice <= r_indice + 8'd1;
                    end else if (w_timeout) begin
                        r_erro <= 1'b1;
                    end else begin
                        r_ocioso <= r_ocioso + 1'b1;
                    end
                end
                VERIFICANDO: begin
                    if (w_transf) begin
                        r_ocioso <= '0;
                        if (w_passa) r_cpu_reset <= 1'b0;
                        else         r_erro      <= 1'b1;
                    end else if (w_timeout) begin
                        r_erro <= 1'b1;
                    end else begin
                        r_ocioso <= r_ocioso + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dado_pronto  = w_pronto;
    assign o_mem_escrita  = r_wr_vld_p1;
    assign o_mem_endereco = r_wr_end_p1;
    assign o_mem_dado     = r_wr_dado_p1;
    // The last data write lands in the first VERIFICANDO cycle, still busy.
    assign o_ocupado      = w_pronto || r_wr_vld_p1;
    assign o_concluido    = (r_estado == FIM);
    assign o_erro         = r_erro;
    assign o_cpu_reset    = r_cpu_reset;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Bench for carregador_instrucoes: two instances (different BASE) share
// stimulus; a transaction-level model predicts acceptance, writes and flags.
module tb_carregador_instrucoes;

    localparam logic [7:0] BASE_A = 8'd0;
    localparam logic [7:0] BASE_B = 8'd254;
    localparam int         TO     = 20;

    logic       clk = 1'b0;
    logic       rst, inicio, vld;
    logic [7:0] tam, dado;

    logic       a_pronto, a_wr, a_ocup, a_concl, a_erro, a_cpurst;
    logic [7:0] a_end, a_dat;
    logic       b_pronto, b_wr, b_ocup, b_concl, b_erro, b_cpurst;
    logic [7:0] b_end, b_dat;

    always #5 clk = ~clk;

    carregador_instrucoes #(.BASE(BASE_A), .TIMEOUT_CICLOS(TO)) u_a (
        .i_clock(clk), .i_reset(rst), .i_inicio(inicio), .i_tamanho(tam),
        .i_dado_valido(vld), .i_dado(dado), .o_dado_pronto(a_pronto),
        .o_mem_escrita(a_wr), .o_mem_endereco(a_end), .o_mem_dado(a_dat),
        .o_ocupado(a_ocup), .o_concluido(a_concl), .o_erro(a_erro),
        .o_cpu_reset(a_cpurst)
    );

    carregador_instrucoes #(.BASE(BASE_B), .TIMEOUT_CICLOS(TO)) u_b (
        .i_clock(clk), .i_reset(rst), .i_inicio(inicio), .i_tamanho(tam),
        .i_dado_valido(vld), .i_dado(dado), .o_dado_pronto(b_pronto),
        .o_mem_escrita(b_wr), .o_mem_endereco(b_end), .o_mem_dado(b_dat),
        .o_ocupado(b_ocup), .o_concluido(b_concl), .o_erro(b_erro),
        .o_cpu_reset(b_cpurst)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: load phase, bytes received, running sum, idle cycles.
    bit         m_busy, m_fim, m_erro, m_cpurst;
    int         m_recv, m_n, m_idle;
    logic [7:0] m_sum;

    logic [7:0] tx [0:255];
    logic [7:0] tx_chk;
    int         obs_wr, t_last, t_fim;
    bit         done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit wr, input logic [7:0] widx, input logic [7:0] wdat);
        logic [7:0] ea, eb;
        ea = BASE_A + widx;
        eb = BASE_B + widx;
        chk("wr_a", a_wr, wr);
        chk("wr_b", b_wr, wr);
        if (wr) begin
            chk("addr_a", a_end, ea);
            chk("addr_b", b_end, eb);
            chk("data_a", a_dat, wdat);
            chk("data_b", b_dat, wdat);
        end
        chk("pronto_a", a_pronto, m_busy);
        chk("pronto_b", b_pronto, m_busy);
        chk("ocupado_a", a_ocup, m_busy || wr);
        chk("ocupado_b", b_ocup, m_busy || wr);
        chk("concluido_a", a_concl, m_fim);
        chk("concluido_b", b_concl, m_fim);
        chk("erro_a", a_erro, m_erro);
        chk("erro_b", b_erro, m_erro);
        chk("cpurst_a", a_cpurst, m_cpurst);
        chk("cpurst_b", b_cpurst, m_cpurst);
    endtask

    // One clock: model predicts what the applied inputs cause, then compares.
    task automatic step();
        bit         acc, wr;
        logic [7:0] widx, wdat, s;
        acc = vld && m_busy;
        wr = 0; widx = 0; wdat = 0;
        @(posedge clk); #1; cyc++;
        if (m_fim) begin
            m_fim = 0;
        end else if (!m_busy) begin
            if (inicio) begin
                m_busy = 1; m_recv = 0; m_n = int'(tam) + 1;
                m_sum = 0; m_idle = 0; m_erro = 0; m_cpurst = 1;
            end
        end else if (acc) begin
            m_idle = 0;
            t_last = cyc;
            if (m_recv < m_n) begin
                wr = 1; widx = 8'(m_recv); wdat = dado;
                m_sum += dado;
                m_recv++;
            end else begin
                s = m_sum + dado;
                m_busy = 0; m_fim = 1;
                m_erro = (s != 8'd0);
                m_cpurst = m_erro;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_busy = 0; m_fim = 1; m_erro = 1;
            end
        end
        if (a_wr === 1'b1) obs_wr++;
        if (a_concl === 1'b1) t_fim = cyc;
        check_outputs(wr, widx, wdat);
    endtask

    task automatic idle(input int n);
        inicio = 0; vld = 0;
        repeat (n) step();
    endtask

    task automatic fill(input int tamv, input bit good);
        logic [7:0] s;
        s = 0;
        for (int i = 0; i <= tamv; i++) begin
            tx[i] = 8'($urandom);
            s += tx[i];
        end
        tx_chk = good ? (8'd0 - s) : (8'd1 - s);
    endtask

    // mode 0: always valid, 1: every other cycle, 2: random, 3: only 2 bytes
    task automatic run_load(input int tamv, input int mode, input int repulse,
                            input int stop_after, output bit fin);
        fin = 0;
        obs_wr = 0;
        tam = 8'(tamv); inicio = 1; vld = 0; dado = 8'($urandom);
        step();
        inicio = 0;
        for (int c = 0; c < 3000; c++) begin
            tam = 8'($urandom);
            inicio = (c == repulse);
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (c % 2) == 1;
                2:       vld = ($urandom % 3) != 0;
                default: vld = (m_recv < 2);
            endcase
            if (vld) dado = (m_recv < m_n) ? tx[m_recv] : tx_chk;
            else     dado = 8'($urandom);
            step();
            if (m_fim) begin fin = 1; break; end
            if (stop_after > 0 && m_recv == stop_after) break;
        end
        inicio = 0; vld = 0;
    endtask

    initial begin
        rst = 1; inicio = 0; vld = 0; tam = 0; dado = 0;
        m_busy = 0; m_fim = 0; m_erro = 0; m_cpurst = 1;
        m_recv = 0; m_n = 0; m_idle = 0; m_sum = 0;
        obs_wr = 0; t_last = 0; t_fim = -1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr_a", a_end, 8'd0);
        chk("rst_data_b", b_dat, 8'd0);
        check_outputs(0, 8'd0, 8'd0);
        rst = 0;
        idle(3);

        // Directed pass: 11 22 33 44 + 56 sums to 0 mod 256
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; tx_chk = 8'h56;
        run_load(3, 0, -1, 0, done);
        chk("pass_done", done, 1);
        chk("pass_writes", obs_wr, 4);
        chk("pass_erro", a_erro, 0);
        chk("pass_cpurst", a_cpurst, 0);
        idle(3);

        // Directed fail: checksum off by one
        tx_chk = 8'h57;
        run_load(3, 0, -1, 0, done);
        chk("fail_done", done, 1);
        chk("fail_writes", obs_wr, 4);
        chk("fail_erro", a_erro, 1);
        chk("fail_cpurst", a_cpurst, 1);
        idle(3);

        // Timeout after 2 of 4 bytes
        fill(3, 1);
        t_fim = -1;
        run_load(3, 3, -1, 0, done);
        chk("to_done", done, 1);
        chk("to_writes", obs_wr, 2);
        chk("to_latency", t_fim - t_last, TO);
        chk("to_erro", b_erro, 1);
        idle(3);

        // Reset right after the 2nd transfer: pending write must vanish
        fill(4, 1);
        run_load(4, 0, -1, 2, done);
        chk("pre_rst_wr", a_wr, 1);
        rst = 1;
        #1;
        m_busy = 0; m_fim = 0; m_erro = 0; m_cpurst = 1;
        check_outputs(0, 8'd0, 8'd0);
        @(posedge clk); #1; cyc++;
        rst = 0;
        obs_wr = 0;
        vld = 1; dado = 8'hA5;
        repeat (5) step();
        chk("post_rst_writes", obs_wr, 0);
        idle(2);

        // Valid toggling with a second inicio mid-load
        fill(9, 1);
        run_load(9, 1, 5, 0, done);
        chk("tog_done", done, 1);
        chk("tog_writes", obs_wr, 10);
        chk("tog_cpurst", a_cpurst, 0);
        idle(2);

        // Random loads including the 1-byte and 256-byte extremes
        for (int k = 0; k < 6; k++) begin
            int  tv;
            bit  good;
            tv   = (k == 0) ? 0 : (k == 1) ? 255 : int'($urandom_range(1, 30));
            good = (k == 1) ? 1'b1 : bit'($urandom % 2);
            fill(tv, good);
            run_load(tv, 2, -1, 0, done);
            chk("rnd_done", done, 1);
            chk("rnd_writes", obs_wr, tv + 1);
            chk("rnd_erro", a_erro, !good);
            idle(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
